// File: rtl/glitch_cmd_pkg.sv
// Shared constants and FSM state type for the glitch command parser.
package glitch_cmd_pkg;

   localparam logic [7:0] SYNC_BYTE      = 8'hA5;
   localparam logic [7:0] OP_SET_OFFSET  = 8'h01;
   localparam logic [7:0] OP_SET_PAYLOAD = 8'h02;
   localparam logic [7:0] OP_ARM         = 8'h03;

   localparam logic [1:0] ERR_CHK     = 2'd0;
   localparam logic [1:0] ERR_LEN     = 2'd1;
   localparam logic [1:0] ERR_OPCODE  = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   localparam logic [7:0] ACK_BYTE = 8'h06;
   localparam logic [7:0] NAK_BYTE = 8'h15;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_OPCODE,
      ST_LEN,
      ST_PAYLOAD,
      ST_CHK
   } state_t;

   function automatic logic opcode_known(input logic [7:0] op);
      return (op == OP_SET_OFFSET) || (op == OP_SET_PAYLOAD) || (op == OP_ARM);
   endfunction

   function automatic logic len_legal(input logic [7:0] op, input logic [7:0] len,
                                      input logic [7:0] max_len);
      logic ok;
      case (op)
         OP_SET_OFFSET:  ok = (len == 8'd3);
         OP_SET_PAYLOAD: ok = (len != 8'd0) && (len <= max_len);
         OP_ARM:         ok = (len == 8'd0);
         default:        ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/glitch_cmd_timeout.sv
// Inter-byte timeout: counts idle cycles while enabled, reloads on every byte strobe.
module glitch_cmd_timeout #(
   parameter int TIMEOUT_CYCLES = 27000
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic enable,
   output logic expire
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt;

   // A byte landing on the expiry cycle suppresses the expiry and restarts the count.
   assign expire = enable && !load && (cnt == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst || load || !enable || expire) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/glitch_cmd_parser.sv
// UART packet parser that commits glitch offset/payload and pulses arm.
// Define GLITCH_CMD_ACK_EN to add the ack_data/ack_valid reply strobe.
module glitch_cmd_parser
   import glitch_cmd_pkg::*;
#(
   parameter int          MAX_PAYLOAD    = 8,
   parameter logic [23:0] DEFAULT_OFFSET = 24'd100,
   parameter logic [7:0]  DEFAULT_BYTE   = 8'h5D,
   parameter int          TIMEOUT_CYCLES = 27000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [7:0]               rx_data,
   input  logic                     rx_valid,
   output logic [23:0]              cfg_offset,
   output logic [8*MAX_PAYLOAD-1:0] cfg_payload,
   output logic [3:0]               cfg_len,
   output logic                     cfg_valid,
   output logic                     arm,
   output logic                     busy,
   output logic                     err,
   output logic [1:0]               err_code,
`ifdef GLITCH_CMD_ACK_EN
   output logic [7:0]               ack_data,
   output logic                     ack_valid,
`endif
   output state_t                   state_dbg
);

   // rx_valid is a single-cycle strobe with no ready: every strobe is consumed the cycle it arrives.
   localparam int SHADOW_N = (MAX_PAYLOAD < 3) ? 3 : MAX_PAYLOAD;

   state_t                  state, state_n;
   logic [7:0]              opcode_q;
   logic [3:0]              len_q;
   logic [3:0]              idx_q;
   logic [7:0]              chk_q;
   logic [8*SHADOW_N-1:0]   shadow;
   logic                    commit_n;
   logic                    err_n;
   logic [1:0]              code_n;
   logic                    expire;

   assign busy      = (state != ST_IDLE);
   assign state_dbg = state;

   glitch_cmd_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk   (clk),
      .rst   (rst),
      .load  (rx_valid),
      .enable(busy),
      .expire(expire)
   );

   always_comb begin
      state_n  = state;
      commit_n = 1'b0;
      err_n    = 1'b0;
      code_n   = ERR_CHK;
      case (state)
         ST_IDLE: begin
            if (rx_valid && rx_data == SYNC_BYTE) state_n = ST_OPCODE;
         end
         ST_OPCODE: begin
            if (rx_valid) begin
               if (opcode_known(rx_data)) begin
                  state_n = ST_LEN;
               end else begin
                  state_n = ST_IDLE;
                  err_n   = 1'b1;
                  code_n  = ERR_OPCODE;
               end
            end
         end
         ST_LEN: begin
            if (rx_valid) begin
               if (!len_legal(opcode_q, rx_data, 8'(MAX_PAYLOAD))) begin
                  state_n = ST_IDLE;
                  err_n   = 1'b1;
                  code_n  = ERR_LEN;
               end else if (rx_data == 8'd0) begin
                  state_n = ST_CHK;
               end else begin
                  state_n = ST_PAYLOAD;
               end
            end
         end
         ST_PAYLOAD: begin
            if (rx_valid && idx_q == len_q - 4'd1) state_n = ST_CHK;
         end
         ST_CHK: begin
            if (rx_valid) begin
               state_n = ST_IDLE;
               if (rx_data == chk_q) begin
                  commit_n = 1'b1;
               end else begin
                  err_n  = 1'b1;
                  code_n = ERR_CHK;
               end
            end
         end
         default: state_n = ST_IDLE;
      endcase
      if (expire) begin
         state_n = ST_IDLE;
         err_n   = 1'b1;
         code_n  = ERR_TIMEOUT;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         opcode_q    <= '0;
         len_q       <= '0;
         idx_q       <= '0;
         chk_q       <= '0;
         shadow      <= '0;
         cfg_offset  <= DEFAULT_OFFSET;
         cfg_payload <= {MAX_PAYLOAD{DEFAULT_BYTE}};
         cfg_len     <= 4'd4;
         cfg_valid   <= 1'b0;
         arm         <= 1'b0;
         err         <= 1'b0;
         err_code    <= ERR_CHK;
`ifdef GLITCH_CMD_ACK_EN
         ack_data    <= '0;
         ack_valid   <= 1'b0;
`endif
      end else begin
         state     <= state_n;
         cfg_valid <= 1'b0;
         arm       <= 1'b0;
         err       <= err_n;
         if (err_n) err_code <= code_n;
         if (rx_valid) begin
            case (state)
               ST_OPCODE: begin
                  opcode_q <= rx_data;
                  chk_q    <= rx_data;
               end
               ST_LEN: begin
                  len_q <= rx_data[3:0];
                  idx_q <= '0;
                  chk_q <= chk_q ^ rx_data;
               end
               ST_PAYLOAD: begin
                  for (int i = 0; i < SHADOW_N; i++) begin
                     if (idx_q == 4'(i)) shadow[8*i +: 8] <= rx_data;
                  end
                  idx_q <= idx_q + 4'd1;
                  chk_q <= chk_q ^ rx_data;
               end
               default: ;
            endcase
         end
         if (commit_n) begin
            case (opcode_q)
               OP_SET_OFFSET: begin
                  cfg_offset <= {shadow[7:0], shadow[15:8], shadow[23:16]};
                  cfg_valid  <= 1'b1;
               end
               OP_SET_PAYLOAD: begin
                  for (int i = 0; i < MAX_PAYLOAD; i++) begin
                     cfg_payload[8*i +: 8] <= (4'(i) < len_q) ? shadow[8*i +: 8] : 8'h00;
                  end
                  cfg_len   <= len_q;
                  cfg_valid <= 1'b1;
               end
               default: arm <= 1'b1;
            endcase
         end
`ifdef GLITCH_CMD_ACK_EN
         ack_valid <= commit_n | err_n;
         ack_data  <= err_n ? NAK_BYTE : ACK_BYTE;
`endif
      end
   end

endmodule

// File: tb/tb_glitch_cmd_parser.sv
// Bench for glitch_cmd_parser: vector table, multi-cycle corner sequences and
// randomized packets checked every cycle against a packet-level reference model.
module tb_glitch_cmd_parser;
   import glitch_cmd_pkg::*;

   localparam int MP = 8;
   localparam int T  = 27000;
   localparam int PW = 8 * MP;
   localparam int NV = 13;

   typedef struct packed {
      logic [127:0]  bytes;
      logic [4:0]    n;
      logic          add_chk;
      logic          ev;
      logic          ea;
      logic          ee;
      logic [1:0]    ec;
      logic [23:0]   off;
      logic [3:0]    len;
      logic [PW-1:0] pay;
   } vec_t;

   logic          clk      = 1'b0;
   logic          rst      = 1'b1;
   logic [7:0]    rx_data  = 8'h00;
   logic          rx_valid = 1'b0;
   logic [23:0]   cfg_offset;
   logic [PW-1:0] cfg_payload;
   logic [3:0]    cfg_len;
   logic          cfg_valid;
   logic          arm;
   logic          busy;
   logic          err;
   logic [1:0]    err_code;
   state_t        state_dbg;
`ifdef GLITCH_CMD_ACK_EN
   logic [7:0]    ack_data;
   logic          ack_valid;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   glitch_cmd_parser #(
      .MAX_PAYLOAD   (MP),
      .DEFAULT_OFFSET(24'd100),
      .DEFAULT_BYTE  (8'h5D),
      .TIMEOUT_CYCLES(T)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .cfg_offset (cfg_offset),
      .cfg_payload(cfg_payload),
      .cfg_len    (cfg_len),
      .cfg_valid  (cfg_valid),
      .arm        (arm),
      .busy       (busy),
      .err        (err),
      .err_code   (err_code),
`ifdef GLITCH_CMD_ACK_EN
      .ack_data   (ack_data),
      .ack_valid  (ack_valid),
`endif
      .state_dbg  (state_dbg)
   );

   // Reference model: bytes of the packet in flight, plus committed configuration.
   logic [7:0]    pkt[$];
   int            idle_cnt = 0;
   logic [23:0]   m_offset = 24'd100;
   logic [PW-1:0] m_pay    = {MP{8'h5D}};
   logic [3:0]    m_len    = 4'd4;
   logic          m_cv     = 1'b0;
   logic          m_arm    = 1'b0;
   logic          m_err    = 1'b0;
   logic [1:0]    m_code   = 2'd0;

   function automatic logic legal_len(input logic [7:0] op, input logic [7:0] ln);
      if (op == 8'h01) return ln == 8'd3;
      if (op == 8'h02) return (ln >= 8'd1) && (int'(ln) <= MP);
      return ln == 8'd0;
   endfunction

   task automatic model_fail(input logic [1:0] code);
      m_err    = 1'b1;
      m_code   = code;
      pkt.delete();
      idle_cnt = 0;
   endtask

   task automatic model_step();
      logic [7:0] c;
      int         n;
      int         ln;
      m_cv  = 1'b0;
      m_arm = 1'b0;
      m_err = 1'b0;
      if (rst) begin
         pkt.delete();
         idle_cnt = 0;
         m_offset = 24'd100;
         m_pay    = {MP{8'h5D}};
         m_len    = 4'd4;
      end else if (rx_valid) begin
         idle_cnt = 0;
         if (pkt.size() == 0) begin
            if (rx_data == 8'hA5) pkt.push_back(rx_data);
         end else begin
            pkt.push_back(rx_data);
            n = pkt.size();
            if (n == 2) begin
               if (pkt[1] < 8'd1 || pkt[1] > 8'd3) model_fail(2'd2);
            end else if (n == 3) begin
               if (!legal_len(pkt[1], pkt[2])) model_fail(2'd1);
            end else if (n == 4 + int'(pkt[2])) begin
               c = 8'h00;
               for (int i = 1; i < n - 1; i++) c ^= pkt[i];
               if (c != pkt[n-1]) begin
                  model_fail(2'd0);
               end else begin
                  ln = int'(pkt[2]);
                  if (pkt[1] == 8'h01) begin
                     m_offset = {pkt[3], pkt[4], pkt[5]};
                     m_cv     = 1'b1;
                  end else if (pkt[1] == 8'h02) begin
                     for (int i = 0; i < MP; i++) begin
                        if (i < ln) m_pay[8*i +: 8] = pkt[3+i];
                        else        m_pay[8*i +: 8] = 8'h00;
                     end
                     m_len = 4'(ln);
                     m_cv  = 1'b1;
                  end else begin
                     m_arm = 1'b1;
                  end
                  pkt.delete();
               end
            end
         end
      end else if (pkt.size() != 0) begin
         idle_cnt++;
         if (idle_cnt == T) model_fail(2'd3);
      end
   endtask

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all();
      check("busy", 128'(busy), 128'(pkt.size() != 0));
      check("cfg_valid", 128'(cfg_valid), 128'(m_cv));
      check("arm", 128'(arm), 128'(m_arm));
      check("err", 128'(err), 128'(m_err));
      if (m_err) check("err_code", 128'(err_code), 128'(m_code));
      check("cfg_offset", 128'(cfg_offset), 128'(m_offset));
      check("cfg_payload", 128'(cfg_payload), 128'(m_pay));
      check("cfg_len", 128'(cfg_len), 128'(m_len));
      check("pulse_excl", 128'($countones({cfg_valid, arm, err}) > 1), 128'(0));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic send(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   function automatic vec_t mkv(input logic [127:0] b, input int n, input logic ac,
                                input logic ev, input logic ea, input logic ee,
                                input logic [1:0] ec, input logic [23:0] off,
                                input logic [3:0] len, input logic [PW-1:0] pay);
      vec_t v;
      v.bytes = b;  v.n  = 5'(n);  v.add_chk = ac;
      v.ev    = ev; v.ea = ea;     v.ee = ee;     v.ec = ec;
      v.off   = off; v.len = len;  v.pay = pay;
      return v;
   endfunction

   vec_t vecs[NV];

   initial begin
      logic [PW-1:0] d5;
      d5 = {MP{8'h5D}};
      // Checksum covers OPCODE, LEN and payload; add_chk appends the correct one.
      vecs[0]  = mkv(128'hA50103_00012C, 6, 1, 1, 0, 0, 2'd0, 24'h00012C, 4'd4, d5);
      vecs[1]  = mkv(128'hA50202_AA55, 5, 1, 1, 0, 0, 2'd0, 24'h00012C, 4'd2, 64'h55AA);
      vecs[2]  = mkv(128'hA50300, 3, 1, 0, 1, 0, 2'd0, 24'h00012C, 4'd2, 64'h55AA);
      vecs[3]  = mkv(128'hA5030004, 4, 0, 0, 0, 1, 2'd0, 24'h00012C, 4'd2, 64'h55AA);
      vecs[4]  = mkv(128'hA507, 2, 0, 0, 0, 1, 2'd2, 24'h00012C, 4'd2, 64'h55AA);
      vecs[5]  = mkv(128'hA50209, 3, 0, 0, 0, 1, 2'd1, 24'h00012C, 4'd2, 64'h55AA);
      vecs[6]  = mkv(128'hA50102, 3, 0, 0, 0, 1, 2'd1, 24'h00012C, 4'd2, 64'h55AA);
      vecs[7]  = mkv(128'hA50301, 3, 0, 0, 0, 1, 2'd1, 24'h00012C, 4'd2, 64'h55AA);
      vecs[8]  = mkv(128'hA50200, 3, 0, 0, 0, 1, 2'd1, 24'h00012C, 4'd2, 64'h55AA);
      vecs[9]  = mkv(128'hA50208_1122334455667788, 11, 1, 1, 0, 0, 2'd0, 24'h00012C, 4'd8,
                     64'h8877665544332211);
      vecs[10] = mkv(128'hA50103_ABCDEF_00, 7, 0, 0, 0, 1, 2'd0, 24'h00012C, 4'd8,
                     64'h8877665544332211);
      vecs[11] = mkv(128'h00FF_A50103_123456, 8, 1, 1, 0, 0, 2'd0, 24'h123456, 4'd8,
                     64'h8877665544332211);
      vecs[12] = mkv(128'hA50201_7E, 4, 1, 1, 0, 0, 2'd0, 24'h123456, 4'd1, 64'h7E);

      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      check("rst_offset", 128'(cfg_offset), 128'(24'd100));
      check("rst_payload", 128'(cfg_payload), 128'(d5));
      check("rst_len", 128'(cfg_len), 128'(4'd4));
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_err_code", 128'(err_code), 128'(0));
      check("rst_pulses", 128'({cfg_valid, arm, err}), 128'(0));

      for (int v = 0; v < NV; v++) begin
         vec_t       cur;
         logic [7:0] b;
         logic [7:0] c;
         logic       started;
         cur     = vecs[v];
         c       = 8'h00;
         started = 1'b0;
         for (int i = 0; i < int'(cur.n); i++) begin
            b = cur.bytes[8*(int'(cur.n) - 1 - i) +: 8];
            if (started) c ^= b;
            else if (b == 8'hA5) started = 1'b1;
            send(b);
         end
         if (cur.add_chk) send(c);
         check($sformatf("vec%0d_cfg_valid", v), 128'(cfg_valid), 128'(cur.ev));
         check($sformatf("vec%0d_arm", v), 128'(arm), 128'(cur.ea));
         check($sformatf("vec%0d_err", v), 128'(err), 128'(cur.ee));
         if (cur.ee) check($sformatf("vec%0d_err_code", v), 128'(err_code), 128'(cur.ec));
         check($sformatf("vec%0d_offset", v), 128'(cfg_offset), 128'(cur.off));
         check($sformatf("vec%0d_len", v), 128'(cfg_len), 128'(cur.len));
         check($sformatf("vec%0d_payload", v), 128'(cfg_payload), 128'(cur.pay));
         idle(1);
      end

      // SYNC on the cycle right after CHK starts the next packet.
      send(8'hA5); send(8'h03); send(8'h00); send(8'h03);
      check("b2b_arm1", 128'(arm), 128'(1));
      send(8'hA5);
      check("b2b_busy", 128'(busy), 128'(1));
      check("b2b_arm_clear", 128'(arm), 128'(0));
      send(8'h03); send(8'h00); send(8'h03);
      check("b2b_arm2", 128'(arm), 128'(1));
      idle(1);

      // Inter-byte timeout.
      send(8'hA5); send(8'h01);
      idle(T - 1);
      check("to_early_err", 128'(err), 128'(0));
      check("to_early_busy", 128'(busy), 128'(1));
      idle(1);
      check("to_err", 128'(err), 128'(1));
      check("to_err_code", 128'(err_code), 128'(2'd3));
      check("to_busy", 128'(busy), 128'(0));
      idle(1);
      check("to_err_clear", 128'(err), 128'(0));

      // A byte on the expiry cycle wins over the timeout.
      send(8'hA5); send(8'h01);
      idle(T - 1);
      send(8'h03);
      check("to_edge_err", 128'(err), 128'(0));
      check("to_edge_busy", 128'(busy), 128'(1));
      send(8'h00); send(8'h00); send(8'h07); send(8'h05);
      check("to_edge_commit", 128'(cfg_valid), 128'(1));
      check("to_edge_offset", 128'(cfg_offset), 128'(24'h000007));
      idle(1);

      // Reset mid-packet discards it silently.
      send(8'hA5); send(8'h01); send(8'h03); send(8'h00);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_mid_err", 128'(err), 128'(0));
      check("rst_mid_offset", 128'(cfg_offset), 128'(24'd100));
      check("rst_mid_busy", 128'(busy), 128'(0));
      send(8'h01); send(8'h2C); send(8'h2F);
      check("rst_mid_no_commit", 128'(cfg_valid), 128'(0));
      check("rst_mid_offset2", 128'(cfg_offset), 128'(24'd100));

      for (int p = 0; p < 200; p++) begin
         logic [7:0] q[$];
         logic [7:0] op;
         logic [7:0] ln;
         logic [7:0] c;
         logic [7:0] b;
         int         kind;
         int         rst_at;
         q.delete();
         kind = int'($urandom_range(0, 9));
         repeat ($urandom_range(0, 2)) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h00;
            q.push_back(b);
         end
         if (kind == 0) op = 8'($urandom_range(4, 255));
         else           op = 8'($urandom_range(1, 3));
         if (kind == 1 || op > 8'd3) ln = 8'($urandom_range(0, 15));
         else if (op == 8'd1)       ln = 8'd3;
         else if (op == 8'd2)       ln = 8'($urandom_range(1, MP));
         else                       ln = 8'd0;
         q.push_back(8'hA5);
         q.push_back(op);
         q.push_back(ln);
         c = op ^ ln;
         for (int i = 0; i < int'(ln); i++) begin
            b = 8'($urandom_range(0, 255));
            q.push_back(b);
            c ^= b;
         end
         if (kind == 2) c ^= 8'($urandom_range(1, 255));
         q.push_back(c);
         rst_at = (kind == 3) ? int'($urandom_range(1, q.size() - 1)) : -1;
         for (int i = 0; i < q.size(); i++) begin
            if (i == rst_at) begin
               rst = 1'b1;
               tick();
               rst = 1'b0;
            end
            idle(int'($urandom_range(0, 3)));
            send(q[i]);
         end
      end
      idle(3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
